instr_encoder: RTL

Converts a set of instruction fields (opcode, rd, rs1, rs2, imm, f3, f7) into a 32-bit RV32I instruction word. It is the inverse of the core's instruction decoder and feeds the instruction memory loader and the self-checking decode testbench. Inputs are accepted through a valid/ready handshake. Encoded words are buffered in a small output FIFO, and illegal field combinations are flagged and counted.

---
 rtl/instr_encoder_if.sv | 35 +++
 rtl/instr_encoder.sv | 134 +++++++++++++
 2 files changed

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: field-set input handshake and encoded-word output handshake
// for instr_encoder.
//   in_valid/in_ready  : field set offered / accepted
//   opcode..f7         : instruction fields to encode
//   out_valid/out_ready: FIFO head offered / consumed
//   out_word/out_err   : head entry (zero when FIFO empty)
//   err_count          : saturating count of accepted erroneous inputs
interface instr_encoder_if #(
  parameter int unsigned COUNT_W = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [6:0]         opcode;
  logic [4:0]         rd;
  logic [4:0]         rs1;
  logic [4:0]         rs2;
  logic [31:0]        imm;
  logic [2:0]         f3;
  logic [6:0]         f7;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_word;
  logic               out_err;
  logic [COUNT_W-1:0] err_count;

  modport master (
    output in_valid, opcode, rd, rs1, rs2, imm, f3, f7, out_ready,
    input  in_ready, out_valid, out_word, out_err, err_count
  );

  modport slave (
    input  in_valid, opcode, rd, rs1, rs2, imm, f3, f7, out_ready,
    output in_ready, out_valid, out_word, out_err, err_count
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I instruction fields into a 32-bit instruction word,
// flags illegal field combinations, buffers {err, word} in a DEPTH-entry FIFO
// and keeps a saturating error counter.
//   clk   : rising-edge clock
//   reset : asynchronous active-high, clears all state
//   bus   : instr_encoder_if slave (input handshake, output FIFO head, err_count)
module instr_encoder #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned COUNT_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  instr_encoder_if.slave  bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [6:0] {
    OP_LOAD   = 7'h03,
    OP_ALUI   = 7'h13,
    OP_AUIPC  = 7'h17,
    OP_STORE  = 7'h23,
    OP_ALU    = 7'h33,
    OP_LUI    = 7'h37,
    OP_BRANCH = 7'h63,
    OP_JALR   = 7'h67,
    OP_JAL    = 7'h6F
  } opcode_t;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
  } fmt_t;

  fmt_t        w_fmt;
  logic [31:0] w_word;
  logic        w_err;
  logic        w_in_ready;
  logic        w_out_valid;
  logic        w_push;
  logic        w_pop;

  logic [32:0]        r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic [COUNT_W-1:0] r_err_cnt;

  always_comb begin
    w_fmt = FMT_BAD;
    case (bus.opcode)
      OP_ALU:                    w_fmt = FMT_R;
      OP_ALUI, OP_LOAD, OP_JALR: w_fmt = FMT_I;
      OP_STORE:                  w_fmt = FMT_S;
      OP_BRANCH:                 w_fmt = FMT_B;
      OP_JAL:                    w_fmt = FMT_J;
      OP_LUI, OP_AUIPC:          w_fmt = FMT_U;
      default:                   w_fmt = FMT_BAD;
    endcase
  end

  // Out-of-range immediates still emit their truncated encoding; only an
  // unknown opcode replaces the word with a NOP.
  always_comb begin
    w_word = 32'h0000_0013;
    w_err  = 1'b0;
    case (w_fmt)
      FMT_R: w_word = {bus.f7, bus.rs2, bus.rs1, bus.f3, bus.rd, bus.opcode};
      FMT_I: begin
        w_word = {bus.imm[11:0], bus.rs1, bus.f3, bus.rd, bus.opcode};
        w_err  = bus.imm != {{20{bus.imm[11]}}, bus.imm[11:0]};
      end
      FMT_S: begin
        w_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.f3, bus.imm[4:0], bus.opcode};
        w_err  = bus.imm != {{20{bus.imm[11]}}, bus.imm[11:0]};
      end
      FMT_B: begin
        w_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.f3,
                  bus.imm[4:1], bus.imm[11], bus.opcode};
        w_err  = (bus.imm != {{19{bus.imm[12]}}, bus.imm[12:0]}) || bus.imm[0];
      end
      FMT_U: begin
        w_word = {bus.imm[31:12], bus.rd, bus.opcode};
        w_err  = bus.imm[11:0] != 12'd0;
      end
      FMT_J: begin
        w_word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                  bus.rd, bus.opcode};
        w_err  = (bus.imm != {{11{bus.imm[20]}}, bus.imm[20:0]}) || bus.imm[0];
      end
      default: begin
        w_word = 32'h0000_0013;
        w_err  = 1'b1;
      end
    endcase
  end

  // in_ready depends only on registered occupancy, never on out_ready.
  assign w_in_ready  = !reset && (r_count < CW'(DEPTH));
  assign w_out_valid = r_count != '0;
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && w_err && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + COUNT_W'(1);
    end
  end

  // Storage needs no reset: occupancy gates everything visible.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_err, w_word};
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_word  = w_out_valid ? r_mem[r_rd_ptr][31:0] : '0;
  assign bus.out_err   = w_out_valid ? r_mem[r_rd_ptr][32]   : 1'b0;
  assign bus.err_count = r_err_cnt;

endmodule
